// File: rtl/tape_prefetch.sv
// Purpose : SDRAM-to-TZX-player tape fetch engine with a small prefetch FIFO, rewind and end-of-tape.
// Latency : player request answered at the next edge when FIFO is non-empty; one cycle after the push when empty.
// Backpr. : reads are issued only while level<DEPTH and one at a time; player requests wait with no timeout.
//
// Ports:
//   clk_sys, reset_n          system clock, synchronous active-low reset
//   dl_active, dl_addr        download stream; image extent is taken from the last dl_addr seen
//   rewind                    one-cycle pulse, restarts playback at address 0
//   mem_rd/mem_addr/mem_ack/mem_data   SDRAM read port (level request, toggle completion)
//   req/ack/data              player toggle handshake, data valid once ack==req
//   tape_reset                registered player restart strobe
//   level, eot                FIFO occupancy, end of tape
module tape_prefetch #(
    parameter int ADDR_W     = 23,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  dl_active,
    input  logic [ADDR_W-1:0]     dl_addr,
    input  logic                  rewind,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_data,
    input  logic                  req,
    output logic                  ack,
    output logic [7:0]            data,
    output logic                  tape_reset,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  eot
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [ADDR_W-1:0]   fetch_addr;
    logic [ADDR_W-1:0]   last_addr;
    logic                loaded;
    logic                ack_seen;
    logic                discard;
    logic                dl_active_q;

    logic [7:0]          fifo_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    logic                flush;
    logic                mem_toggle;
    logic                start_rd;
    logic                push;
    logic                pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Download and rewind both empty the FIFO and restart from address 0.
    assign flush      = dl_active | rewind;
    assign mem_toggle = (mem_ack != ack_seen);

    assign start_rd = (state == S_IDLE) & loaded & ~dl_active & ~rewind &
                      (level < LVL_W'(DEPTH)) & (fetch_addr <= last_addr);

    // A completion that races with a flush is dropped as well: the flush wins.
    assign push = (state == S_READ) & mem_toggle & ~discard & ~flush;
    // A pending player request survives a flush and is served after refill.
    assign pop  = (req != ack) & (level != '0) & ~flush;

    assign eot = loaded & (fetch_addr > last_addr) & (level == '0) & ~mem_rd;

    // Fetch FSM state register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch FSM next state; the SDRAM port cannot abort, so READ always waits for its toggle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_rd)   state_nxt = S_READ;
            S_READ: if (mem_toggle) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage, no reset needed: contents are only read below level
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            ack         <= 1'b0;
            data        <= 8'h00;
            level       <= '0;
            tape_reset  <= 1'b1;
            loaded      <= 1'b0;
            fetch_addr  <= '0;
            last_addr   <= '0;
            discard     <= 1'b0;
            dl_active_q <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            // Resynchronise to the current toggle level so a stale edge is never taken as a completion.
            ack_seen    <= mem_ack;
        end else begin
            dl_active_q <= dl_active;
            tape_reset  <= flush;

            // Image extent tracks the download; an empty download still leaves one byte at address 0.
            if (dl_active) begin
                last_addr <= dl_addr;
                loaded    <= 1'b0;
            end else if (dl_active_q) begin
                loaded    <= 1'b1;
            end

            if (start_rd) begin
                mem_rd   <= 1'b1;
                mem_addr <= fetch_addr;
            end

            if (state == S_READ) begin
                if (mem_toggle) begin
                    ack_seen <= mem_ack;
                    mem_rd   <= 1'b0;
                    discard  <= 1'b0;
                end else if (flush) begin
                    discard  <= 1'b1;
                end
            end

            if (flush) begin
                fetch_addr <= '0;
            end else if (push) begin
                fetch_addr <= fetch_addr + ADDR_W'(1);
            end

            if (pop) begin
                data <= fifo_mem[rd_ptr];
                ack  <= req;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                if (push && !pop) begin
                    level <= level + LVL_W'(1);
                end else if (pop && !push) begin
                    level <= level - LVL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tape_prefetch.sv
module tb_tape_prefetch;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        dl_active = 1'b0;
    logic [22:0] dl_addr = '0;
    logic        rewind = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;

    // instance A: default depth 8, SDRAM model with manual override
    logic        mem_rd_a, ack_a, tape_reset_a, eot_a;
    logic [22:0] mem_addr_a;
    logic [7:0]  data_a;
    logic [3:0]  level_a;
    logic        mem_ack_a = 1'b0;
    logic [7:0]  mem_data_a = 8'h00;

    // instance B: depth 4, automatic SDRAM model
    logic        mem_rd_b, ack_b, tape_reset_b, eot_b;
    logic [22:0] mem_addr_b;
    logic [7:0]  data_b;
    logic [2:0]  level_b;
    logic        mem_ack_b = 1'b0;
    logic [7:0]  mem_data_b = 8'h00;

    int tests = 0;
    int fails = 0;

    always #5 clk_sys = ~clk_sys;

    tape_prefetch #(.ADDR_W(23), .DEPTH_LOG2(3)) u_dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_addr(dl_addr),
        .rewind(rewind), .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_ack(mem_ack_a),
        .mem_data(mem_data_a), .req(req_a), .ack(ack_a), .data(data_a),
        .tape_reset(tape_reset_a), .level(level_a), .eot(eot_a)
    );

    tape_prefetch #(.ADDR_W(23), .DEPTH_LOG2(2)) u_dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_addr(dl_addr),
        .rewind(1'b0), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_ack(mem_ack_b),
        .mem_data(mem_data_b), .req(req_b), .ack(ack_b), .data(data_b),
        .tape_reset(tape_reset_b), .level(level_b), .eot(eot_b)
    );

    function automatic logic [7:0] img_a(input logic [22:0] a);
        case (a)
            23'd0:   return 8'h11;
            23'd1:   return 8'h22;
            23'd2:   return 8'h33;
            23'd3:   return 8'h44;
            23'd4:   return 8'h55;
            default: return 8'hEE;
        endcase
    endfunction

    function automatic logic [7:0] img_b(input logic [22:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // SDRAM model A: counts read issues, answers after 3 cycles in auto mode,
    // or answers immediately with man_data_a whenever man_req_a is bumped.
    bit          auto_a = 1'b1;
    int          man_req_a = 0;
    int          man_done_a = 0;
    logic [7:0]  man_data_a = 8'h00;
    int          nreads_a = 0;
    logic [22:0] addrs_a [$];
    bit          rd_q_a = 1'b0;
    bit          busy_a = 1'b0;
    int          cnt_a = 0;

    always @(negedge clk_sys) begin
        if (mem_rd_a && !rd_q_a) begin
            nreads_a++;
            addrs_a.push_back(mem_addr_a);
        end
        rd_q_a = mem_rd_a;
        if (man_req_a != man_done_a) begin
            mem_data_a = man_data_a;
            mem_ack_a  = ~mem_ack_a;
            man_done_a++;
        end else if (auto_a && mem_rd_a) begin
            if (!busy_a) begin
                busy_a = 1'b1;
                cnt_a  = 3;
            end else if (cnt_a > 1) begin
                cnt_a--;
            end else begin
                mem_data_a = img_a(mem_addr_a);
                mem_ack_a  = ~mem_ack_a;
                busy_a     = 1'b0;
            end
        end else if (!mem_rd_a) begin
            busy_a = 1'b0;
        end
    end

    int nreads_b = 0;
    bit rd_q_b = 1'b0;
    bit busy_b = 1'b0;
    int cnt_b = 0;

    always @(negedge clk_sys) begin
        if (mem_rd_b && !rd_q_b) nreads_b++;
        rd_q_b = mem_rd_b;
        if (mem_rd_b) begin
            if (!busy_b) begin
                busy_b = 1'b1;
                cnt_b  = 2;
            end else if (cnt_b > 1) begin
                cnt_b--;
            end else begin
                mem_data_b = img_b(mem_addr_b);
                mem_ack_b  = ~mem_ack_b;
                busy_b     = 1'b0;
            end
        end else begin
            busy_b = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // hand one completion to model A; returns just after the edge that samples it
    task automatic man_resp(input logic [7:0] d);
        man_data_a = d;
        man_req_a++;
        tick();
    endtask

    task automatic wait_rd_a();
        for (int i = 0; i < 20 && !mem_rd_a; i++) tick();
        tests++; if (mem_rd_a !== 1'b1) begin fails++; $display("FAIL rd_issue: mem_rd=%b want 1", mem_rd_a); end
    endtask

    task automatic load(input int nbytes);
        dl_active = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            dl_addr = 23'(i);
            tick();
        end
        tests++; if (tape_reset_a !== 1'b1) begin fails++; $display("FAIL dl_tape_reset: got %b want 1", tape_reset_a); end
        tests++; if (level_a !== 4'd0) begin fails++; $display("FAIL dl_level: got %0d want 0", level_a); end
        dl_active = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        tests++; if (mem_rd_a !== 1'b0)     begin fails++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd_a); end
        tests++; if (mem_addr_a !== 23'd0)  begin fails++; $display("FAIL rst_mem_addr: got %0h want 0", mem_addr_a); end
        tests++; if (ack_a !== 1'b0)        begin fails++; $display("FAIL rst_ack: got %b want 0", ack_a); end
        tests++; if (data_a !== 8'h00)      begin fails++; $display("FAIL rst_data: got %h want 00", data_a); end
        tests++; if (level_a !== 4'd0)      begin fails++; $display("FAIL rst_level: got %0d want 0", level_a); end
        tests++; if (eot_a !== 1'b0)        begin fails++; $display("FAIL rst_eot: got %b want 0", eot_a); end
        tests++; if (tape_reset_a !== 1'b1) begin fails++; $display("FAIL rst_tape_reset: got %b want 1", tape_reset_a); end
        reset_n = 1'b1;
        tick();
        tests++; if (tape_reset_a !== 1'b0) begin fails++; $display("FAIL rst_release_tape_reset: got %b want 0", tape_reset_a); end
        // raise mem_ack to 1 while idle, then pulse reset for one cycle
        man_resp(8'h99);
        tests++; if (level_a !== 4'd0) begin fails++; $display("FAIL idle_toggle_level: got %0d want 0", level_a); end
        reset_n = 1'b0;
        tick();
        tests++; if (tape_reset_a !== 1'b1) begin fails++; $display("FAIL rst1_tape_reset: got %b want 1", tape_reset_a); end
        tests++; if (level_a !== 4'd0)      begin fails++; $display("FAIL rst1_level: got %0d want 0", level_a); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        int base;
        logic [7:0] exp_d [5];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44; exp_d[4] = 8'h55;
        base = addrs_a.size();
        load(5);
        for (int i = 0; i < 200 && level_a != 4'd5; i++) tick();
        tests++; if (level_a !== 4'd5) begin fails++; $display("FAIL load_level: got %0d want 5", level_a); end
        repeat (10) tick();
        tests++; if (addrs_a.size() - base !== 5) begin fails++; $display("FAIL load_nreads: got %0d want 5", addrs_a.size() - base); end
        for (int k = 0; k < 5 && base + k < addrs_a.size(); k++) begin
            tests++; if (addrs_a[base + k] !== 23'(k)) begin fails++; $display("FAIL load_addr%0d: got %0h want %0h", k, addrs_a[base + k], k); end
        end
        tests++; if (mem_rd_a !== 1'b0) begin fails++; $display("FAIL load_mem_rd_idle: got %b want 0", mem_rd_a); end
        tests++; if (eot_a !== 1'b0)    begin fails++; $display("FAIL load_eot_early: got %b want 0", eot_a); end
        for (int k = 0; k < 5; k++) begin
            req_a = ~req_a;
            tick();
            tests++; if (ack_a !== req_a)     begin fails++; $display("FAIL play%0d_ack: got %b want %b", k, ack_a, req_a); end
            tests++; if (data_a !== exp_d[k]) begin fails++; $display("FAIL play%0d_data: got %h want %h", k, data_a, exp_d[k]); end
        end
        tick();
        tests++; if (level_a !== 4'd0) begin fails++; $display("FAIL play_level: got %0d want 0", level_a); end
        tests++; if (eot_a !== 1'b1)   begin fails++; $display("FAIL play_eot: got %b want 1", eot_a); end
    endtask

    task automatic test_depth();
        int base;
        base = nreads_b;
        load(100);
        repeat (60) tick();
        tests++; if (nreads_b - base !== 4) begin fails++; $display("FAIL depth_nreads: got %0d want 4", nreads_b - base); end
        tests++; if (level_b !== 3'd4)      begin fails++; $display("FAIL depth_level: got %0d want 4", level_b); end
        tests++; if (mem_rd_b !== 1'b0)     begin fails++; $display("FAIL depth_mem_rd: got %b want 0", mem_rd_b); end
        req_b = ~req_b;
        tick();
        tests++; if (level_b !== 3'd3)      begin fails++; $display("FAIL depth_pop_level: got %0d want 3", level_b); end
        tests++; if (ack_b !== req_b)       begin fails++; $display("FAIL depth_ack: got %b want %b", ack_b, req_b); end
        tests++; if (data_b !== 8'h5A)      begin fails++; $display("FAIL depth_data: got %h want 5a", data_b); end
        repeat (20) tick();
        tests++; if (nreads_b - base !== 5) begin fails++; $display("FAIL depth_refill_nreads: got %0d want 5", nreads_b - base); end
        tests++; if (level_b !== 3'd4)      begin fails++; $display("FAIL depth_refill_level: got %0d want 4", level_b); end
    endtask

    task automatic test_rewind();
        auto_a = 1'b0;
        req_a = ~req_a;
        tick();
        wait_rd_a();
        tests++; if (mem_addr_a !== 23'd8) begin fails++; $display("FAIL rw_pre_addr: got %0h want 8", mem_addr_a); end
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        tests++; if (level_a !== 4'd0)      begin fails++; $display("FAIL rw_flush_level: got %0d want 0", level_a); end
        tests++; if (tape_reset_a !== 1'b1) begin fails++; $display("FAIL rw_tape_reset_on: got %b want 1", tape_reset_a); end
        tests++; if (mem_rd_a !== 1'b1)     begin fails++; $display("FAIL rw_mem_rd_held: got %b want 1", mem_rd_a); end
        tick();
        tests++; if (tape_reset_a !== 1'b0) begin fails++; $display("FAIL rw_tape_reset_off: got %b want 0", tape_reset_a); end
        repeat (8) tick();
        tests++; if (mem_rd_a !== 1'b1)     begin fails++; $display("FAIL rw_mem_rd_wait: got %b want 1", mem_rd_a); end
        man_resp(8'hC3);
        tests++; if (level_a !== 4'd0)      begin fails++; $display("FAIL rw_discard_level: got %0d want 0", level_a); end
        tests++; if (mem_rd_a !== 1'b0)     begin fails++; $display("FAIL rw_discard_mem_rd: got %b want 0", mem_rd_a); end
        wait_rd_a();
        tests++; if (mem_addr_a !== 23'd0)  begin fails++; $display("FAIL rw_restart_addr: got %0h want 0", mem_addr_a); end
        man_resp(8'h11);
        tests++; if (level_a !== 4'd1)      begin fails++; $display("FAIL rw_refill_level: got %0d want 1", level_a); end
    endtask

    task automatic test_empty_req();
        req_a = ~req_a;
        tick();
        tests++; if (data_a !== 8'h11) begin fails++; $display("FAIL er_first_data: got %h want 11", data_a); end
        tests++; if (level_a !== 4'd0) begin fails++; $display("FAIL er_first_level: got %0d want 0", level_a); end
        req_a = ~req_a;
        repeat (3) tick();
        tests++; if (ack_a === req_a)  begin fails++; $display("FAIL er_pending: ack=%b req=%b want differ", ack_a, req_a); end
        wait_rd_a();
        man_resp(8'hA5);
        tests++; if (level_a !== 4'd1) begin fails++; $display("FAIL er_push_level: got %0d want 1", level_a); end
        tests++; if (ack_a === req_a)  begin fails++; $display("FAIL er_ack_early: ack=%b req=%b want differ", ack_a, req_a); end
        tick();
        tests++; if (ack_a !== req_a)  begin fails++; $display("FAIL er_ack: got %b want %b", ack_a, req_a); end
        tests++; if (data_a !== 8'hA5) begin fails++; $display("FAIL er_data: got %h want a5", data_a); end
        tests++; if (level_a !== 4'd0) begin fails++; $display("FAIL er_level: got %0d want 0", level_a); end
    endtask

    task automatic test_back_to_back();
        wait_rd_a();
        man_resp(8'h77);
        tests++; if (level_a !== 4'd1) begin fails++; $display("FAIL bb_level1: got %0d want 1", level_a); end
        wait_rd_a();
        req_a = ~req_a;
        man_resp(8'h88);
        tests++; if (level_a !== 4'd1) begin fails++; $display("FAIL bb_pushpop_level: got %0d want 1", level_a); end
        tests++; if (data_a !== 8'h77) begin fails++; $display("FAIL bb_pushpop_data: got %h want 77", data_a); end
        tests++; if (ack_a !== req_a)  begin fails++; $display("FAIL bb_pushpop_ack: got %b want %b", ack_a, req_a); end
        req_a = ~req_a;
        tick();
        tests++; if (data_a !== 8'h88) begin fails++; $display("FAIL bb_next_data: got %h want 88", data_a); end
        tests++; if (level_a !== 4'd0) begin fails++; $display("FAIL bb_next_level: got %0d want 0", level_a); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_depth();
        test_rewind();
        test_empty_req();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tape_prefetch.md
# tape_prefetch

Tape-playback fetch engine between the SDRAM tape port and the TZX player. It buffers bytes of a downloaded tape image in a parametrised prefetch FIFO so the player's toggle request is answered in one cycle instead of one SDRAM round trip. It tracks the image extent from the download stream and supports rewind and end-of-tape detection. It replaces the single-byte, unbuffered fetch logic in the machine top level.

## Interface
Parameters:
- ADDR_W, 23, SDRAM tape address width.
- DEPTH_LOG2, 3, log2 of the FIFO depth (DEPTH = 2**DEPTH_LOG2 bytes, minimum 1).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- dl_active  in  1  tape image download in progress.
- dl_addr  in  ADDR_W  address of the byte currently being downloaded.
- rewind  in  1  one-cycle pulse; restart playback from address 0.
- mem_rd  out  1  SDRAM read request level.
- mem_addr  out  ADDR_W  SDRAM read address.
- mem_ack  in  1  SDRAM completion toggle.
- mem_data  in  8  SDRAM read data; valid in the cycle mem_ack toggles.
- req  in  1  player data request toggle.
- ack  out  1  player acknowledge toggle.
- data  out  8  byte to player; valid once ack equals req.
- tape_reset  out  1  player restart strobe.
- level  out  DEPTH_LOG2+1  FIFO occupancy.
- eot  out  1  end of tape: image exhausted and FIFO empty.

## Operation
- Registers:
  - fetch_addr: next SDRAM address to read.
  - last_addr: final image byte address.
  - loaded: an image is present.
  - ack_seen: last sampled mem_ack.
  - discard: the in-flight read must be dropped.
  - FIFO storage with read and write pointers (DEPTH_LOG2 bits, wrapping) and the level counter.
- Reset (reset_n=0): outputs take these values:
  - mem_rd=0, mem_addr=0, ack=0, data=0, level=0, eot=0, tape_reset=1.
  - Internally: loaded=0, fetch_addr=0, last_addr=0, discard=0, and ack_seen<=mem_ack, so a stale toggle is never counted.
- Download (dl_active=1):
  - FIFO flushed, fetch_addr<=0, last_addr<=dl_addr every cycle, tape_reset=1, loaded<=0.
  - On the falling edge of dl_active, loaded<=1.
  - An empty download leaves last_addr=0, so a single byte is played.
- Fetch FSM with two states:
  - IDLE -> READ when loaded & ~dl_active & level<DEPTH & fetch_addr<=last_addr & ~rewind. Action: mem_rd<=1, mem_addr<=fetch_addr.
  - READ -> IDLE when mem_ack!=ack_seen. Actions: ack_seen<=mem_ack, mem_rd<=0.
    - If ~discard: push mem_data and fetch_addr<=fetch_addr+1.
    - Otherwise: discard<=0 and nothing is pushed.
- Only one read is ever in flight, and a read starts only when level<DEPTH, so the FIFO never overflows.
- Consumer:
  - When req!=ack and level!=0: data<=FIFO head, pop, ack<=req.
  - When level=0 the request stays pending with no timeout; it is served as soon as a byte is pushed.
- rewind or dl_active while in READ:
  - mem_rd stays asserted until the toggle arrives, because the SDRAM port cannot abort.
  - discard<=1, and the returning byte is dropped.
- rewind:
  - FIFO flushed, fetch_addr<=0, tape_reset=1 for one cycle.
  - A pending player request remains pending and is served after refill.
  - rewind while dl_active has no effect beyond the download behaviour.
- Simultaneous push and pop: both performed, level unchanged. Pop from the only entry while pushing is legal.
- Flush coinciding with push or pop: the flush wins, so level=0 and the pointers are zeroed.
- eot = loaded & fetch_addr>last_addr & level==0 & ~mem_rd.
- Address arithmetic is ADDR_W-bit unsigned. fetch_addr is never incremented past last_addr+1, so it does not wrap for last_addr < 2**ADDR_W-1.

## Timing
- Player latency, FIFO non-empty: req toggles in cycle N, ack and data update at the edge ending N; visible in N+1.
- Player latency, FIFO empty: ack follows one cycle after the push edge.
- Read issue: mem_rd rises one cycle after the IDLE conditions hold.
- Back-to-back reads: a new read issues at the earliest one cycle after the previous toggle.
- tape_reset is registered:
  - Asserted the cycle after dl_active or rewind is sampled.
  - Held throughout dl_active.
  - Deasserted the cycle after dl_active falls.
- Full throughput equals the SDRAM toggle rate. The player never observes the SDRAM latency while level>0.

## Test plan
- Load 5 bytes (dl_addr 0..4, values 11,22,33,44,55), then drop dl_active:
  - Reads addresses 0..4 only; level peaks at 5.
  - Five req toggles return 11,22,33,44,55, each acked in 1 cycle.
  - eot=1 afterwards.
- DEPTH_LOG2=2, 100-byte image, no player requests:
  - Exactly 4 reads issued; level=4; mem_rd stays 0.
  - One req toggle gives level 3, then one further read.
- Rewind while mem_rd=1 and the SDRAM acks 10 cycles later:
  - The late byte is discarded and level stays 0.
  - Next read is at address 0; tape_reset is pulsed for 1 cycle.
- req toggled with FIFO empty, mem_ack toggling with data A5:
  - ack follows 1 cycle after the push; data=A5; level returns to 0.
- Push and pop in the same cycle at level=1:
  - level stays 1; data equals the old head; the new byte is next.
- reset_n low for 1 cycle while mem_ack is at 1:
  - No push occurs; outputs take their reset values; tape_reset=1 during reset.
